lcd_hd44780_driver: RTL and testbench
=====================================

// Module: lcd_hd44780_driver
// PURPOSE
//  Responder end of the lcd_enable/lcd_bus/busy handshake used by the menu/player
//  controller. Sends the HD44780 power-on init sequence, then accepts one 10-bit
//  command/character per handshake and drives rs/rw/en/db with correct setup, pulse
//  and execute timing. Sits between the controller and the 16x2 LCD pins.
// PARAMETERS
//  CLK_FREQ   50     clock frequency in MHz; 1 us = CLK_FREQ cycles
//  T_PWR_US   50000  power-on wait before the first init command, in us
//  T_CMD_US   50     execute wait after a normal command or character, in us
//  T_CLR_US   2000   execute wait after clear (0x01) or home (0x02) with rs=0, in us
// PORTS
//  clk         in   1   system clock, rising edge
//  rst         in   1   asynchronous, active-low reset
//  lcd_enable  in   1   request strobe; sampled only while busy=0
//  lcd_bus     in   10  [10]=rs, [9]=rw (ignored), [8:1]=data/instruction
//  busy        out  1   1 = init in progress or a transaction is pending
//  rs          out  1   LCD register select
//  rw          out  1   LCD read/write; always driven 0 (write only)
//  en          out  1   LCD enable strobe
//  lcd_data    out  8   LCD DB7..DB0
// BEHAVIOUR
//  Reset (rst=0, async): busy=1, rs=0, rw=0, en=0, lcd_data=0; FSM->PWR_WAIT; timer cleared.
//  FSM: PWR_WAIT -> INIT -> SETUP -> EN_HI -> EXEC -> {INIT | READY}; READY -> SETUP on accept.
//  PWR_WAIT: wait T_PWR_US*CLK_FREQ cycles, then INIT with init index 0.
//  INIT: load rs=0 and lcd_data from ROM[idx]: 0x38, 0x0C, 0x01, 0x06; idx++.
//  SETUP: rs/lcd_data stable, en=0, CLK_FREQ cycles (1 us).
//  EN_HI: en=1 for CLK_FREQ cycles; rs/lcd_data unchanged.
//  EXEC: en=0; wait T_CLR_US*CLK_FREQ if rs=0 and data is 0x01 or 0x02,
//   else T_CMD_US*CLK_FREQ. Then INIT if idx<4, else READY.
//  READY: busy=0. Accept when lcd_enable=1 and busy=0 at a clk edge: latch
//   rs<=lcd_bus[10], lcd_data<=lcd_bus[8:1]; busy=1 from that same edge; -> SETUP.
//  Handshake is level-sensitive: enable held high re-accepts on every return to READY;
//   enable while busy=1 is ignored and not queued.
//  Outputs are registered. rs/lcd_data hold the last value in READY. en is never
//   high outside EN_HI.
//  Timer: one down-counter, 22 bits minimum, so T_PWR_US*CLK_FREQ=2.5e6 fits.
//   Load value = N-1; state advances on the cycle the count reaches 0.
//  Reset mid-operation: en drops immediately; init sequence restarts from PWR_WAIT.
//  Transaction length from accept to busy=0: 2*CLK_FREQ + exec cycles (+1 READY cycle).
// CONFIGURATION
//  LCD_CURSOR_EN defined: init ROM[1]=0x0F (display on, cursor on, blink on).
//  LCD_CURSOR_EN undefined: ROM[1]=0x0C (display on, cursor off). No other difference.
// STRUCTURE
//  Package lcd_pkg: FSM state encoding; init ROM constants; LCD_CLEAR=0x01,
//   LCD_HOME=0x02; line-address constants 0x80/0xC0 for the controller.
//  Sub-module lcd_delay_timer: load/value in, done out; shared by all waits.
// TESTING (CLK_FREQ=1, T_PWR_US=100, T_CMD_US=5, T_CLR_US=20)
//  Reset release -> busy=1 for 100 cycles, then four en pulses with data 38,0C,01,06
//   and rs=0; wait after 01 is 20 cycles; busy falls after 06 wait.
//  READY, bus=10'b10_01000001 with enable for 1 cycle -> rs=1, data=0x41,
//   en high 1 cycle after 1 setup cycle, busy low 5 cycles later.
//  bus=10'b00_00000001 -> 20-cycle exec wait; bus=10'b00_10000000 -> 5-cycle wait.
//  Enable pulsed while busy=1 -> no en pulse, no change on rs/lcd_data.
//  Enable held high, 3 characters on bus -> exactly one en pulse per READY visit.
//  rst=0 during EN_HI -> en=0 and busy=1 immediately; full init replays after release.
//  LCD_CURSOR_EN defined -> second init byte 0x0F.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD driver.
// LCD_CURSOR_EN selects a visible blinking cursor in the power-on init sequence.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_INIT     = 3'd1,
    ST_SETUP    = 3'd2,
    ST_EN_HI    = 3'd3,
    ST_EXEC     = 3'd4,
    ST_READY    = 3'd5
  } lcd_state_e;

  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME  = 8'h02;
  localparam logic [7:0] LCD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_LINE2 = 8'hC0;

  localparam int INIT_LEN    = 4;
  localparam int TIMER_MIN_W = 22;

  localparam logic [7:0] INIT_FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] INIT_ENTRY_MODE = 8'h06;  // increment, no shift
`ifdef LCD_CURSOR_EN
  localparam logic [7:0] INIT_DISPLAY    = 8'h0F;
`else
  localparam logic [7:0] INIT_DISPLAY    = 8'h0C;
`endif

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return INIT_FUNC_SET;
      2'd1:    return INIT_DISPLAY;
      2'd2:    return LCD_CLEAR;
      default: return INIT_ENTRY_MODE;
    endcase
  endfunction

  // Clear and home are the only instructions with the long execute time.
  function automatic logic needs_long_exec(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CLEAR || data == LCD_HOME);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Shared down-counter for every LCD wait: load N-1, done is high while the count is 0.
module lcd_delay_timer #(
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  assign done = (count == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (!done) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/lcd_hd44780_driver.sv
// HD44780 write-only driver: power-on init, then one command/character per handshake.
// Define LCD_CURSOR_EN to turn on the blinking cursor during init.
module lcd_hd44780_driver
  import lcd_pkg::*;
#(
  parameter int CLK_FREQ = 50,
  parameter int T_PWR_US = 50000,
  parameter int T_CMD_US = 50,
  parameter int T_CLR_US = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_enable,
  input  logic [10:1] lcd_bus,
  output logic        busy,
  output logic        rs,
  output logic        rw,
  output logic        en,
  output logic [7:0]  lcd_data
);

  localparam int PWR_CYC = T_PWR_US * CLK_FREQ;
  localparam int CMD_CYC = T_CMD_US * CLK_FREQ;
  localparam int CLR_CYC = T_CLR_US * CLK_FREQ;
  localparam int MAX_CYC = (PWR_CYC > CLR_CYC) ? ((PWR_CYC > CMD_CYC) ? PWR_CYC : CMD_CYC)
                                               : ((CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC);
  localparam int TW      = ($clog2(MAX_CYC + 1) > TIMER_MIN_W) ? $clog2(MAX_CYC + 1) : TIMER_MIN_W;

  localparam logic [TW-1:0] PWR_LOAD = TW'(PWR_CYC - 1);
  localparam logic [TW-1:0] CMD_LOAD = TW'(CMD_CYC - 1);
  localparam logic [TW-1:0] CLR_LOAD = TW'(CLR_CYC - 1);
  localparam logic [TW-1:0] US_LOAD  = TW'(CLK_FREQ - 1);

  lcd_state_e    state, state_n;
  logic          armed;
  logic [2:0]    idx;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_done;
  logic          ld_init;
  logic          ld_bus;
  logic          unused_rw_bit;

  // The controller's rw bit has no meaning for a write-only panel.
  assign unused_rw_bit = lcd_bus[9];
  assign rw            = 1'b0;

  lcd_delay_timer #(.WIDTH(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    tmr_load  = 1'b0;
    tmr_value = '0;
    ld_init   = 1'b0;
    ld_bus    = 1'b0;
    case (state)
      ST_PWR_WAIT: begin
        // Reset leaves the timer cleared, so the first cycle arms the power-on wait.
        if (!armed) begin
          tmr_load  = 1'b1;
          tmr_value = PWR_LOAD;
        end else if (tmr_done) begin
          state_n = ST_INIT;
        end
      end
      ST_INIT: begin
        ld_init   = 1'b1;
        tmr_load  = 1'b1;
        tmr_value = US_LOAD;
        state_n   = ST_SETUP;
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = US_LOAD;
          state_n   = ST_EN_HI;
        end
      end
      ST_EN_HI: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = needs_long_exec(rs, lcd_data) ? CLR_LOAD : CMD_LOAD;
          state_n   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (tmr_done) begin
          state_n = (idx < 3'(INIT_LEN)) ? ST_INIT : ST_READY;
        end
      end
      ST_READY: begin
        if (lcd_enable) begin
          ld_bus    = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = US_LOAD;
          state_n   = ST_SETUP;
        end
      end
      default: state_n = ST_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_PWR_WAIT;
      armed    <= 1'b0;
      idx      <= '0;
      rs       <= 1'b0;
      lcd_data <= '0;
      en       <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state <= state_n;
      if (state == ST_PWR_WAIT) begin
        armed <= 1'b1;
      end
      if (ld_init) begin
        rs       <= 1'b0;
        lcd_data <= init_rom(idx[1:0]);
        idx      <= idx + 3'd1;
      end else if (ld_bus) begin
        rs       <= lcd_bus[10];
        lcd_data <= lcd_bus[8:1];
      end
      // Pin outputs follow the next state so they are registered yet aligned with it.
      en   <= (state_n == ST_EN_HI);
      busy <= (state_n != ST_READY);
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Self-checking bench for lcd_hd44780_driver: transaction-level timing model plus literal pins.
module tb_lcd_hd44780_driver;

  localparam int CLK_F = 1;
  localparam int T_PWR = 100;
  localparam int T_CMD = 5;
  localparam int T_CLR = 20;

`ifdef LCD_CURSOR_EN
  localparam logic [7:0] ROM1 = 8'h0F;
`else
  localparam logic [7:0] ROM1 = 8'h0C;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_in = 1'b0;
  logic [10:1] bus = '0;
  logic        busy, rs, rw, en;
  logic [7:0]  lcd_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] init_bytes [4] = '{8'h38, ROM1, 8'h01, 8'h06};

  lcd_hd44780_driver #(
    .CLK_FREQ(CLK_F), .T_PWR_US(T_PWR), .T_CMD_US(T_CMD), .T_CLR_US(T_CLR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lcd_enable (en_in),
    .lcd_bus    (bus),
    .busy       (busy),
    .rs         (rs),
    .rw         (rw),
    .en         (en),
    .lcd_data   (lcd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model ----------------
  // Each write is an item starting on the edge its rs/data appear: en is high during
  // [s+CLK, s+2*CLK) and busy ends at s+2*CLK+exec. Init items follow one cycle apart;
  // the first starts after one arming cycle, the power-on wait and one load cycle.
  int         cyc;
  int         s_item, e_item, next_init, init_k;
  logic       m_item, m_ready;
  logic       m_busy, m_en, m_rs;
  logic [7:0] m_data;

  function automatic int exec_len(input logic r, input logic [7:0] d);
    return (!r && (d == 8'h01 || d == 8'h02)) ? T_CLR * CLK_F : T_CMD * CLK_F;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        cyc = 0; m_item = 0; m_ready = 0; init_k = 0;
        next_init = T_PWR * CLK_F + 2;
        m_busy = 1; m_en = 0; m_rs = 0; m_data = '0;
      end else begin
        cyc++;
        if (!m_item && !m_ready && init_k < 4 && cyc == next_init) begin
          s_item = cyc; m_rs = 0; m_data = init_bytes[init_k]; init_k++;
          e_item = s_item + 2 * CLK_F + exec_len(m_rs, m_data); m_item = 1;
        end else if (m_ready && en_in) begin
          s_item = cyc; m_rs = bus[10]; m_data = bus[8:1]; m_ready = 0;
          e_item = s_item + 2 * CLK_F + exec_len(m_rs, m_data); m_item = 1;
        end
        if (m_item && cyc == e_item) begin
          m_item = 0;
          if (init_k < 4) next_init = cyc + 1;
          else m_ready = 1;
        end
        m_busy = !m_ready;
        m_en   = m_item && cyc >= s_item + CLK_F && cyc < s_item + 2 * CLK_F;
      end
    end
  end

  // One compare per cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst)
        check("outputs{busy,en,rs,rw,data}", {20'd0, busy, en, rs, rw, lcd_data},
              {20'd0, m_busy, m_en, m_rs, 1'b0, m_data});
    end
  end

  // ---------------- Event monitor for literal pins ----------------
  int         en_rise_c, en_fall_c, busy_rise_c, busy_fall_c, en_pulses;
  int         rise_q[$];
  logic [7:0] byte_q[$];
  logic       prev_en, prev_busy;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        prev_en = 0; prev_busy = 1;
      end else begin
        if (en && !prev_en) begin
          en_rise_c = cyc; en_pulses++;
          rise_q.push_back(cyc); byte_q.push_back(lcd_data);
        end
        if (!en && prev_en) en_fall_c = cyc;
        if (busy && !prev_busy) busy_rise_c = cyc;
        if (!busy && prev_busy) busy_fall_c = cyc;
        prev_en = en; prev_busy = busy;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- Stimulus helpers ----------------
  task automatic wait_busy(input logic lvl, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === lvl) break;
    end
    check(name, busy, lvl);
  endtask

  task automatic check_init_pins(input string tag);
    int exp_rise [4] = '{103, 111, 119, 142};
    check({tag, "_pulse_count"}, rise_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < rise_q.size()) begin
        check($sformatf("%s_rise%0d", tag, k), rise_q[k], exp_rise[k]);
        check($sformatf("%s_byte%0d", tag, k), byte_q[k], init_bytes[k]);
      end
    end
    check({tag, "_busy_fall"}, busy_fall_c, 148);
  endtask

  task automatic run_txn(input logic [10:1] v, input int exp_exec, input string name);
    int p0;
    p0 = en_pulses;
    @(negedge clk);
    en_in = 1'b1; bus = v;
    @(negedge clk);
    en_in = 1'b0;
    wait_busy(1'b0, 200, {name, "_done"});
    check({name, "_setup"}, en_rise_c - busy_rise_c, 1);
    check({name, "_pulse"}, en_fall_c - en_rise_c, 1);
    check({name, "_exec"}, busy_fall_c - en_fall_c, exp_exec);
    check({name, "_npulse"}, en_pulses - p0, 1);
    check({name, "_data"}, {rs, lcd_data}, {v[10], v[8:1]});
  endtask

  // ---------------- Main sequence ----------------
  logic [10:1] chars [3] = '{10'b10_01001000, 10'b10_01101001, 10'b10_00100001};

  initial begin
    #2 rst = 1'b0;
    #20;
    check("rst_busy", busy, 1'b1);
    check("rst_en", en, 1'b0);
    check("rst_rs", rs, 1'b0);
    check("rst_rw", rw, 1'b0);
    check("rst_data", lcd_data, 8'h00);
    rise_q.delete(); byte_q.delete();
    @(negedge clk) rst = 1'b1;

    wait_busy(1'b0, 400, "init_done");
    check_init_pins("init");

    run_txn(10'b10_01000001, 5,  "char_A");
    run_txn(10'b00_00000001, 20, "clear");
    run_txn(10'b00_10000000, 5,  "line1");
    run_txn(10'b00_00000010, 20, "home");
    run_txn(10'b10_00000001, 5,  "rs1_01");
    run_txn(10'b00_00000011, 5,  "cmd_03");

    // Enable pulsed while busy is ignored and not queued.
    begin
      int p0;
      p0 = en_pulses;
      @(negedge clk); en_in = 1'b1; bus = 10'b10_01001000;
      @(negedge clk); en_in = 1'b0;
      @(negedge clk); en_in = 1'b1; bus = 10'b11_11111111;
      @(negedge clk); en_in = 1'b0;
      wait_busy(1'b0, 200, "ignore_done");
      repeat (3) @(negedge clk);
      check("ignore_npulse", en_pulses - p0, 1);
      check("ignore_data", {rs, lcd_data}, 9'h148);
    end

    // Enable held high: one accept per READY visit.
    begin
      int p0;
      p0 = en_pulses;
      @(negedge clk); en_in = 1'b1; bus = chars[0];
      for (int k = 0; k < 3; k++) begin
        wait_busy(1'b1, 50, $sformatf("held_accept%0d", k));
        if (k < 2) bus = chars[k + 1];
        else en_in = 1'b0;
        if (k < 2) wait_busy(1'b0, 100, $sformatf("held_done%0d", k));
      end
      wait_busy(1'b0, 100, "held_done2");
      repeat (3) @(negedge clk);
      check("held_npulse", en_pulses - p0, 3);
      check("held_last", {rs, lcd_data}, 9'h121);
    end

    // Randomized traffic with stray enables while busy.
    for (int i = 0; i < 30; i++) begin
      int gap, hold, r;
      logic       rsb;
      logic [7:0] d;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      r   = $urandom_range(0, 3);
      d   = (r == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom_range(0, 255));
      rsb = (r == 0) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      bus = {rsb, 1'($urandom_range(0, 1)), d};
      en_in = 1'b1;
      hold = $urandom_range(1, 3);
      repeat (hold) @(negedge clk);
      en_in = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk); en_in = 1'b1; bus = 10'($urandom_range(0, 1023));
        @(negedge clk); en_in = 1'b0;
      end
      wait_busy(1'b0, 100, "rand_done");
    end

    // Reset during EN_HI: immediate en drop, then a full init replay.
    @(negedge clk); en_in = 1'b1; bus = 10'b10_01011010;
    @(negedge clk); en_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (en === 1'b1) break;
      @(negedge clk);
    end
    check("midrst_en_seen", en, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("midrst_en", en, 1'b0);
    check("midrst_busy", busy, 1'b1);
    check("midrst_rs", rs, 1'b0);
    check("midrst_data", lcd_data, 8'h00);
    rise_q.delete(); byte_q.delete();
    @(negedge clk) rst = 1'b1;
    wait_busy(1'b0, 400, "replay_done");
    check_init_pins("replay");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
